// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: raw instruction -> one-hot op vector, register indices, immediate.
// Latency 1 cycle (accept in N, out_valid in N+1); full throughput via 2-entry skid buffer.
// Backpressure: in_ready is registered and drops only when OUT and SKID are both occupied.
// Optional build macro DEC_ILLEGAL_TRAP_EN: deliver illegal encodings flagged on out_illegal
// instead of dropping them at accept.
module rv32i_decode_stage #(
  parameter int XLEN    = 32,
  parameter int INSTR_W = 47
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [XLEN-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instructions,
  output logic [4:0]         out_rs1,
  output logic [4:0]         out_rs2,
  output logic [4:0]         out_rd,
  output logic [XLEN-1:0]    out_imm,
  output logic [XLEN-1:0]    out_pc
`ifdef DEC_ILLEGAL_TRAP_EN
  ,
  output logic               out_illegal
`endif
);

  // Bit positions in the one-hot instruction vector.
  localparam int B_ADD   = 0;
  localparam int B_SUB   = 1;
  localparam int B_XOR   = 2;
  localparam int B_OR    = 3;
  localparam int B_AND   = 4;
  localparam int B_SLL   = 5;
  localparam int B_SRL   = 6;
  localparam int B_SRA   = 7;
  localparam int B_SLT   = 8;
  localparam int B_SLTU  = 9;
  localparam int B_ADDI  = 10;
  localparam int B_XORI  = 11;
  localparam int B_ORI   = 12;
  localparam int B_ANDI  = 13;
  localparam int B_SLLI  = 14;
  localparam int B_SRLI  = 15;
  localparam int B_SRAI  = 16;
  localparam int B_SLTI  = 17;
  localparam int B_SLTIU = 18;
  localparam int B_LB    = 19;
  localparam int B_LH    = 20;
  localparam int B_LW    = 21;
  localparam int B_LBU   = 22;
  localparam int B_LHU   = 23;
  localparam int B_SB    = 24;
  localparam int B_SH    = 25;
  localparam int B_SW    = 26;
  localparam int B_BEQ   = 27;
  localparam int B_BNE   = 28;
  localparam int B_BLT   = 29;
  localparam int B_BGE   = 30;
  localparam int B_BLTU  = 31;
  localparam int B_BGEU  = 32;
  localparam int B_JAL   = 33;
  localparam int B_JALR  = 34;
  localparam int B_LUI   = 35;
  localparam int B_AUIPC = 36;
  localparam int B_ECALL = 37;
  localparam int B_EBRK  = 38;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Operand/immediate layout of the decoded instruction; F_N means no operands.
  typedef enum logic [2:0] {F_R, F_I, F_SH, F_S, F_B, F_U, F_J, F_N} fmt_e;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] op;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [XLEN-1:0]    imm;
    logic [XLEN-1:0]    pc;
`ifdef DEC_ILLEGAL_TRAP_EN
    logic               illegal;
`endif
  } entry_t;

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic [INSTR_W-1:0] dec_op;
  logic               dec_illegal;
  fmt_e               dec_fmt;
  entry_t             dec_entry;

  state_e state_q, state_d;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  logic   accept;
  logic   drain;
  logic   push;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  // Classify the opcode/funct fields into a single one-hot bit and an operand format.
  always_comb begin
    dec_op  = '0;
    dec_fmt = F_N;
    case (opcode)
      OP_R: begin
        dec_fmt = F_R;
        if (funct7 == 7'h00) begin
          case (funct3)
            3'd0: dec_op[B_ADD]  = 1'b1;
            3'd1: dec_op[B_SLL]  = 1'b1;
            3'd2: dec_op[B_SLT]  = 1'b1;
            3'd3: dec_op[B_SLTU] = 1'b1;
            3'd4: dec_op[B_XOR]  = 1'b1;
            3'd5: dec_op[B_SRL]  = 1'b1;
            3'd6: dec_op[B_OR]   = 1'b1;
            default: dec_op[B_AND] = 1'b1;
          endcase
        end else if (funct7 == 7'h20) begin
          if (funct3 == 3'd0) dec_op[B_SUB] = 1'b1;
          else if (funct3 == 3'd5) dec_op[B_SRA] = 1'b1;
        end
      end
      OP_IMM: begin
        dec_fmt = F_I;
        case (funct3)
          3'd0: dec_op[B_ADDI]  = 1'b1;
          3'd2: dec_op[B_SLTI]  = 1'b1;
          3'd3: dec_op[B_SLTIU] = 1'b1;
          3'd4: dec_op[B_XORI]  = 1'b1;
          3'd6: dec_op[B_ORI]   = 1'b1;
          3'd7: dec_op[B_ANDI]  = 1'b1;
          3'd1: begin
            dec_fmt = F_SH;
            if (funct7 == 7'h00) dec_op[B_SLLI] = 1'b1;
          end
          default: begin
            dec_fmt = F_SH;
            if (funct7 == 7'h00) dec_op[B_SRLI] = 1'b1;
            else if (funct7 == 7'h20) dec_op[B_SRAI] = 1'b1;
          end
        endcase
      end
      OP_LOAD: begin
        dec_fmt = F_I;
        case (funct3)
          3'd0: dec_op[B_LB]  = 1'b1;
          3'd1: dec_op[B_LH]  = 1'b1;
          3'd2: dec_op[B_LW]  = 1'b1;
          3'd4: dec_op[B_LBU] = 1'b1;
          3'd5: dec_op[B_LHU] = 1'b1;
          default: ;
        endcase
      end
      OP_STORE: begin
        dec_fmt = F_S;
        case (funct3)
          3'd0: dec_op[B_SB] = 1'b1;
          3'd1: dec_op[B_SH] = 1'b1;
          3'd2: dec_op[B_SW] = 1'b1;
          default: ;
        endcase
      end
      OP_BRANCH: begin
        dec_fmt = F_B;
        case (funct3)
          3'd0: dec_op[B_BEQ]  = 1'b1;
          3'd1: dec_op[B_BNE]  = 1'b1;
          3'd4: dec_op[B_BLT]  = 1'b1;
          3'd5: dec_op[B_BGE]  = 1'b1;
          3'd6: dec_op[B_BLTU] = 1'b1;
          3'd7: dec_op[B_BGEU] = 1'b1;
          default: ;
        endcase
      end
      OP_JAL: begin
        dec_fmt         = F_J;
        dec_op[B_JAL]   = 1'b1;
      end
      OP_JALR: begin
        dec_fmt = F_I;
        if (funct3 == 3'd0) dec_op[B_JALR] = 1'b1;
      end
      OP_LUI: begin
        dec_fmt         = F_U;
        dec_op[B_LUI]   = 1'b1;
      end
      OP_AUIPC: begin
        dec_fmt         = F_U;
        dec_op[B_AUIPC] = 1'b1;
      end
      OP_SYSTEM: begin
        // Only the two exact encodings are legal: all other fields must be zero.
        if (in_instr[31:7] == 25'h0000000) dec_op[B_ECALL] = 1'b1;
        else if (in_instr[31:7] == 25'h0002000) dec_op[B_EBRK] = 1'b1;
      end
      default: ;
    endcase
    // Anything that set no bit is illegal; this also covers in_instr[1:0] != 2'b11.
    dec_illegal = ~|dec_op;
    if (dec_illegal) dec_fmt = F_N;
  end

  // Extract register indices and the immediate according to the operand format.
  always_comb begin
    dec_entry     = '0;
    dec_entry.op  = dec_op;
    dec_entry.pc  = in_pc;
`ifdef DEC_ILLEGAL_TRAP_EN
    dec_entry.illegal = dec_illegal;
`endif
    case (dec_fmt)
      F_R: begin
        dec_entry.rs1 = in_instr[19:15];
        dec_entry.rs2 = in_instr[24:20];
        dec_entry.rd  = in_instr[11:7];
      end
      F_I: begin
        dec_entry.rs1 = in_instr[19:15];
        dec_entry.rd  = in_instr[11:7];
        dec_entry.imm = XLEN'($signed(in_instr[31:20]));
      end
      F_SH: begin
        dec_entry.rs1 = in_instr[19:15];
        dec_entry.rd  = in_instr[11:7];
        dec_entry.imm = XLEN'(in_instr[24:20]);
      end
      F_S: begin
        dec_entry.rs1 = in_instr[19:15];
        dec_entry.rs2 = in_instr[24:20];
        dec_entry.imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      end
      F_B: begin
        dec_entry.rs1 = in_instr[19:15];
        dec_entry.rs2 = in_instr[24:20];
        dec_entry.imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                       in_instr[11:8], 1'b0}));
      end
      F_U: begin
        dec_entry.rd  = in_instr[11:7];
        dec_entry.imm = XLEN'($signed({in_instr[31:12], 12'h000}));
      end
      F_J: begin
        dec_entry.rd  = in_instr[11:7];
        dec_entry.imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                       in_instr[30:21], 1'b0}));
      end
      default: ;
    endcase
  end

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid & out_ready;

`ifdef DEC_ILLEGAL_TRAP_EN
  assign push = accept;
`else
  // Illegal words are consumed from fetch but never become an entry.
  assign push = accept & ~dec_illegal;
`endif

  // Skid-buffer occupancy: next state and which register receives new data.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (push) begin
            state_d = S_ONE;
            out_d   = dec_entry;
          end
        end
        S_ONE: begin
          if (push && !drain) begin
            state_d = S_TWO;
            skid_d  = dec_entry;
          end else if (push && drain) begin
            out_d   = dec_entry;
          end else if (drain) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (drain) begin
            state_d = S_ONE;
            out_d   = skid_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
    in_ready_d = (state_d != S_TWO);
  end

  // State, data and registered in_ready; reset clears every output field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready         = in_ready_q;
  assign out_valid        = (state_q != S_EMPTY);
  assign out_instructions = out_q.op;
  assign out_rs1          = out_q.rs1;
  assign out_rs2          = out_q.rs2;
  assign out_rd           = out_q.rd;
  assign out_imm          = out_q.imm;
  assign out_pc           = out_q.pc;
`ifdef DEC_ILLEGAL_TRAP_EN
  assign out_illegal      = out_q.illegal;
`endif

endmodule
